// File: rtl/fifo_rd_drain_packer.sv
// Read-side FIFO drain: pops words, packs PACK of them per beat and emits them through a 2-entry output buffer.
// Defining DRAIN_STATS_EN adds word_cnt / stall_cnt statistics outputs.
`timescale 1ns/1ps
module fifo_rd_drain_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                       r_clk,
  input  logic                       rrst,
  input  logic                       fifo_empty,
  output logic                       fifo_r_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data_out,
  input  logic                       fifo_read_error,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic [ERR_CNT_W-1:0]       rd_err_cnt
`ifdef DRAIN_STATS_EN
  ,
  output logic [31:0]                word_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int LW = $clog2(PACK + 1);
  localparam int BW = DATA_WIDTH * PACK;

  logic [LW-1:0]         lane_cnt_q, lane_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DATA_WIDTH-1:0] lane_q [PACK];
  logic [DATA_WIDTH-1:0] lane_d [PACK];
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]         buf_data_q [2];
  logic [BW-1:0]         buf_data_d [2];
  logic [PACK-1:0]       buf_keep_q [2];
  logic [PACK-1:0]       buf_keep_d [2];
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic          hs, cap_last, flush_exec, push;
  logic [2:0]    eff_cnt, occ;
  logic [BW-1:0] push_data;
  logic [PACK-1:0] push_keep;

  assign m_valid    = (out_cnt_q != 2'd0);
  assign m_data     = buf_data_q[rd_ptr_q];
  assign m_keep     = buf_keep_q[rd_ptr_q];
  assign rd_err_cnt = err_cnt_q;

  // Occupancy after this cycle's handshake, plus the word that is still on its way.
  assign hs        = m_valid && m_ready;
  assign eff_cnt   = {1'b0, out_cnt_q} - {2'b00, hs};
  assign occ       = eff_cnt + {2'b00, inflight_q};
  assign fifo_r_en = !rrst && !fifo_empty && !flush_pend_q && (occ < 3'd2);

  assign cap_last   = inflight_q && (lane_cnt_q == LW'(PACK - 1));
  assign flush_exec = flush_pend_q && !inflight_q && (eff_cnt < 3'd2);
  assign push       = cap_last || (flush_exec && (lane_cnt_q != '0));

  // Unused lanes are kept at zero, so a partial beat needs no extra masking.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign push_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (inflight_q && (lane_cnt_q == LW'(gi))) ? fifo_data_out : lane_q[gi];
      assign push_keep[gi] = cap_last || (lane_cnt_q > LW'(gi));
    end
  endgenerate

  always_comb begin
    inflight_d = fifo_r_en;
    lane_cnt_d = lane_cnt_q;
    for (int i = 0; i < PACK; i++) begin
      lane_d[i] = lane_q[i];
      if (inflight_q && (lane_cnt_q == LW'(i))) lane_d[i] = fifo_data_out;
      if (cap_last || flush_exec) lane_d[i] = '0;
    end
    if (cap_last || flush_exec) lane_cnt_d = '0;
    else if (inflight_q)        lane_cnt_d = lane_cnt_q + LW'(1);

    if (PACK == 1)       flush_pend_d = 1'b0;
    else if (flush_exec) flush_pend_d = 1'b0;
    else                 flush_pend_d = flush_pend_q || flush;
  end

  always_comb begin
    out_cnt_d = out_cnt_q + {1'b0, push} - {1'b0, hs};
    rd_ptr_d  = rd_ptr_q ^ hs;
    wr_ptr_d  = wr_ptr_q ^ push;
    for (int i = 0; i < 2; i++) begin
      buf_data_d[i] = buf_data_q[i];
      buf_keep_d[i] = buf_keep_q[i];
    end
    if (push) begin
      buf_data_d[wr_ptr_q] = push_data;
      buf_keep_d[wr_ptr_q] = push_keep;
    end
    err_cnt_d = err_cnt_q;
    if (fifo_read_error && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      lane_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_cnt_q    <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      err_cnt_q    <= '0;
      for (int i = 0; i < PACK; i++) lane_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_keep_q[i] <= '0;
      end
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      out_cnt_q    <= out_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      err_cnt_q    <= err_cnt_d;
      for (int i = 0; i < PACK; i++) lane_q[i] <= lane_d[i];
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_keep_q[i] <= buf_keep_d[i];
      end
    end
  end

`ifdef DRAIN_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d, keep_ones;

  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    keep_ones = '0;
    for (int i = 0; i < PACK; i++) keep_ones = keep_ones + {31'd0, m_keep[i]};
    word_cnt_d  = hs ? (word_cnt_q + keep_ones) : word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule
